// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port among NUM_REQ sprite drawers.
// Optional starvation guard (max pixels per grant) enabled by PIXEL_ARB_STARVE_GUARD_EN.
module pixel_write_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     pix_valid,
    input  logic [NUM_REQ*8-1:0]   x_in,
    input  logic [NUM_REQ*7-1:0]   y_in,
    input  logic [NUM_REQ*3-1:0]   color_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [2:0]             owner,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             color_out,
    output logic                   write_en,
    output logic                   busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_t;

    state_t       state;
    logic [2:0]   ptr;
    logic [7:0]   req_pad;
    logic         found;
    logic [2:0]   winner;
    logic [3:0]   cand;
    logic [NUM_REQ-1:0] win_onehot;

    logic         cur_req;
    logic         cur_valid;
    logic [7:0]   cur_x;
    logic [6:0]   cur_y;
    logic [2:0]   cur_color;
    logic         accept;
    logic         force_release;

    assign req_pad = 8'(req);

    // Scan ptr+1, ptr+2, ... wrapping at NUM_REQ; the last owner is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = 4'(ptr) + 4'(i);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (!found && req_pad[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_onehot[i] = (winner == 3'(i));
        end
    end

    always_comb begin
        cur_req   = 1'b0;
        cur_valid = 1'b0;
        cur_x     = '0;
        cur_y     = '0;
        cur_color = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner == 3'(i)) begin
                cur_req   = req[i];
                cur_valid = pix_valid[i];
                cur_x     = x_in[8*i +: 8];
                cur_y     = y_in[7*i +: 7];
                cur_color = color_in[3*i +: 3];
            end
        end
    end

`ifdef PIXEL_ARB_STARVE_GUARD_EN
    logic [7:0] burst;

    // Pixels beyond the burst limit are dropped until the grant falls.
    assign accept        = (state == StGrant) && cur_valid && (burst < 8'(MAX_BURST));
    assign force_release = accept && (burst == 8'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst <= '0;
        end else if (state == StIdle) begin
            burst <= '0;
        end else if (accept) begin
            burst <= burst + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign accept        = (state == StGrant) && cur_valid;
    assign force_release = 1'b0;
    assign unused_cfg    = ^8'(MAX_BURST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            gnt       <= '0;
            owner     <= '0;
            ptr       <= 3'(NUM_REQ - 1);
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            write_en  <= 1'b0;
        end else begin
            write_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        gnt   <= win_onehot;
                        owner <= winner;
                        state <= StGrant;
                    end
                end
                StGrant: begin
                    if (accept) begin
                        x_out     <= cur_x;
                        y_out     <= cur_y;
                        color_out <= cur_color;
                        write_en  <= 1'b1;
                    end
                    // A pixel in the release cycle is still written above.
                    if (!cur_req || force_release) begin
                        gnt   <= '0;
                        ptr   <= owner;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state == StGrant) | write_en;

endmodule
